prog_run_checker: RTL and testbench

- Synthesizable program-run harness that wraps `top_level` in self-checking regressions.
- Pulses the DUT reset, waits for `done` with a cycle watchdog, then walks the register file read port and compares each register against expected values.
- Reports pass/fail, mismatch count, first failing address and program cycle count.
- Generalised in data width, register count and timeout; one instance serves every program test.

---
 rtl/prog_check_pkg.sv | 9 +
 rtl/sat_counter.sv | 20 ++
 rtl/prog_run_checker.sv | 118 +++++++++++
 tb/tb_prog_run_checker.sv | 131 +++++++++++++
 4 files changed

// File: rtl/prog_check_pkg.sv
// prog_check_pkg: shared state encoding and default widths for the program-run checker
package prog_check_pkg;
   typedef enum logic [2:0] {IDLE, RST, RUN, CHECK, REPORT} chk_state_t;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_RST_CYC  = 2;
   localparam int DEF_TIMEOUT  = 4096;
   localparam int DEF_CYC_W    = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with clear that sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             at_max
);
   logic [WIDTH-1:0] cnt_q;
   assign cnt    = cnt_q;
   assign at_max = &cnt_q;
   // count enabled cycles, holding at the top value
   always_ff @(posedge clk) begin
      if (reset || clr) cnt_q <= '0;
      else if (en && !at_max) cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/prog_run_checker.sv
// prog_run_checker: resets a program DUT, waits for done with a watchdog, then scans its register file
module prog_run_checker
   import prog_check_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int RST_CYC  = DEF_RST_CYC,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int CYC_W    = DEF_CYC_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NUM_REGS-1:0] check_mask,
   output logic                dut_reset,
   input  logic                dut_done,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [DATA_W-1:0]   rd_data,
   input  logic [DATA_W-1:0]   exp_data,
   output logic                busy,
   output logic                fin,
   output logic                pass,
   output logic                timed_out,
   output logic [ADDR_W:0]     err_cnt,
   output logic [ADDR_W-1:0]   first_err,
   output logic [CYC_W-1:0]    cycles
);
   localparam int RC_W = $clog2(RST_CYC + 1);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   chk_state_t        state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, first_err_q, first_err_d;
   logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
   logic              timed_out_q, timed_out_d;
   logic              clr, run_en, mism;
   logic [WD_W-1:0]   wd_cnt;
   logic              cyc_max_unused, wd_max_unused;

   sat_counter #(.WIDTH(CYC_W)) u_cycles (
      .clk(clk), .reset(reset), .clr(clr), .en(run_en), .cnt(cycles), .at_max(cyc_max_unused)
   );
   sat_counter #(.WIDTH(WD_W)) u_watchdog (
      .clk(clk), .reset(reset), .clr(clr), .en(run_en), .cnt(wd_cnt), .at_max(wd_max_unused)
   );

   assign mism      = check_mask[addr_q] && (rd_data != exp_data);
   assign dut_reset = reset || (state_q == RST);
   assign rd_addr   = addr_q;
   assign busy      = (state_q == RST) || (state_q == RUN) || (state_q == CHECK);
   assign fin       = (state_q == REPORT);
   assign pass      = fin && !timed_out_q && (err_cnt_q == '0);
   assign timed_out = timed_out_q;
   assign err_cnt   = err_cnt_q;
   assign first_err = first_err_q;

   // state and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rst_cnt_q   <= '0;
         addr_q      <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         addr_q      <= addr_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         timed_out_q <= timed_out_d;
      end
   end

   // sequencing: reset pulse, watched run, register scan, report
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      addr_d      = addr_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      timed_out_d = timed_out_q;
      clr         = 1'b0;
      run_en      = 1'b0;
      case (state_q)
         IDLE, REPORT: if (start) begin
            state_d     = RST;
            rst_cnt_d   = '0;
            addr_d      = '0;
            err_cnt_d   = '0;
            first_err_d = '0;
            timed_out_d = 1'b0;
            clr         = 1'b1;
         end
         RST: begin
            state_d   = (rst_cnt_q == RC_W'(RST_CYC - 1)) ? RUN : RST;
            rst_cnt_d = rst_cnt_q + 1'b1;
         end
         RUN: if (dut_done) state_d = CHECK;
         else begin
            run_en = 1'b1;
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
               timed_out_d = 1'b1;
               state_d     = REPORT;
            end
         end
         CHECK: begin
            err_cnt_d   = mism ? err_cnt_q + 1'b1 : err_cnt_q;
            first_err_d = (mism && err_cnt_q == '0) ? addr_q : first_err_q;
            state_d     = (addr_q == ADDR_W'(NUM_REGS - 1)) ? REPORT : CHECK;
            addr_d      = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_prog_run_checker.sv
// tb_prog_run_checker: directed and randomized program runs against a result-level model
module tb_prog_run_checker;
   localparam int NR = 8, TO = 100, RC = 2;

   logic          clk = 0, reset = 1, start = 0, dut_done = 0;
   logic [NR-1:0] check_mask = '1;
   logic          dut_reset, busy, fin, pass, timed_out;
   logic [2:0]    rd_addr, first_err;
   logic [3:0]    err_cnt;
   logic [15:0]   cycles;
   logic [7:0]    regs [NR];
   logic [7:0]    expv [NR];
   logic [7:0]    rd_data, exp_data;
   int            checks = 0, errors = 0;

   assign rd_data  = regs[rd_addr];
   assign exp_data = expv[rd_addr];

   always #5 clk = ~clk;

   prog_run_checker #(.DATA_W(8), .NUM_REGS(NR), .RST_CYC(RC), .TIMEOUT(TO), .CYC_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .check_mask(check_mask),
      .dut_reset(dut_reset), .dut_done(dut_done), .rd_addr(rd_addr),
      .rd_data(rd_data), .exp_data(exp_data), .busy(busy), .fin(fin),
      .pass(pass), .timed_out(timed_out), .err_cnt(err_cnt),
      .first_err(first_err), .cycles(cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   // n: RUN cycles before done (-1 = never); glitch: done high only during RST; stuck: done high throughout
   task automatic run(input string tag, input int n, input bit glitch, input bit stuck, input bit mid_start);
      int  e_err = 0, e_first = 0, e_cyc, e_lat, fin_k = -1, rst_hi = 0, moves = 0;
      bit  tmo = !stuck && n < 0;
      for (int i = 0; i < NR; i++)
         if (check_mask[i] && regs[i] != expv[i]) begin
            if (e_err == 0) e_first = i;
            e_err++;
         end
      if (tmo) begin e_err = 0; e_first = 0; end
      e_cyc = stuck ? 0 : (tmo ? TO : n);
      e_lat = tmo ? RC + TO : RC + e_cyc + 1 + NR;
      dut_done = stuck;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      for (int k = 0; k < 400 && fin_k < 0; k++) begin
         if (fin) fin_k = k;
         else begin
            rst_hi += int'(dut_reset);
            if (rd_addr != 0) moves++;
            dut_done = stuck || (glitch && k < 2) || (n >= 0 && k >= 2 + n);
            start    = mid_start && k == 5;
            @(negedge clk);
         end
      end
      dut_done = 0;
      start    = 0;
      chk({tag, "_latency"}, fin_k, e_lat);
      chk({tag, "_rst_len"}, rst_hi, RC);
      chk({tag, "_addr_moves"}, moves, tmo ? 0 : NR - 1);
      chk({tag, "_err_cnt"}, err_cnt, e_err);
      chk({tag, "_first_err"}, first_err, e_first);
      chk({tag, "_cycles"}, cycles, e_cyc);
      chk({tag, "_timed_out"}, timed_out, tmo);
      chk({tag, "_pass"}, pass, !tmo && e_err == 0);
      @(negedge clk);
      chk({tag, "_held"}, {busy, fin, err_cnt, cycles}, {1'b0, 1'b1, 4'(e_err), 16'(e_cyc)});
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin regs[i] = 8'(i * 17); expv[i] = 8'(i * 17); end
      repeat (3) @(negedge clk);
      chk("reset_outputs", {dut_reset, busy, fin, pass, timed_out, err_cnt, first_err, cycles, rd_addr},
          {1'b1, 4'b0, 4'd0, 3'd0, 16'd0, 3'd0});
      reset = 0;
      @(negedge clk);
      chk("idle_dut_reset", {dut_reset, busy, fin}, 3'b000);

      run("all_match", 37, 0, 0, 0);
      regs[3] = 8'd2; expv[3] = 8'd3; regs[7] = 8'd0; expv[7] = 8'h80;
      run("two_mism", 12, 0, 0, 0);
      check_mask = 8'h77;
      run("masked", 9, 0, 0, 0);
      check_mask = 8'h00;
      run("mask_zero", 3, 0, 0, 0);
      check_mask = 8'hFF;
      run("timeout", -1, 0, 0, 0);
      run("ignore_start_done", 20, 1, 0, 1);
      run("stuck_done", 0, 0, 1, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NR; i++) begin
            regs[i] = 8'($urandom);
            expv[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : regs[i];
         end
         check_mask = 8'($urandom);
         run($sformatf("rand%0d", r), int'($urandom_range(4, 90)), 0, 0, 0);
      end

      check_mask = 8'hFF;
      for (int i = 0; i < NR; i++) begin regs[i] = 8'(i); expv[i] = 8'(i + 1); end
      dut_done = 1;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      begin
         int w = 0;
         while (!(busy && rd_addr == 3'd4) && w < 50) begin @(negedge clk); w++; end
         chk("reach_addr4", w < 50, 1);
      end
      reset = 1;
      dut_done = 0;
      @(negedge clk);
      chk("midreset_state", {dut_reset, busy, fin, err_cnt, rd_addr}, {3'b100, 4'd0, 3'd0});
      @(negedge clk);
      chk("midreset_hold", dut_reset, 1);
      reset = 0;
      @(negedge clk);
      chk("midreset_idle", {dut_reset, busy, fin}, 3'b000);
      for (int i = 0; i < NR; i++) expv[i] = regs[i];
      run("after_reset", 15, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
